// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM control unit:
// FSM states, datapath select codes, ALU codes and condition evaluation.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH,
        S_UNKNOWN
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;

    localparam logic [1:0] SRCA_REG      = 2'b00;
    localparam logic [1:0] SRCA_PC       = 2'b10;
    localparam logic [1:0] SRCB_WDATA    = 2'b00;
    localparam logic [1:0] SRCB_IMM      = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // Flags are packed {N,Z,C,V}; the never code 1111 falls to the default.
    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cond)
            COND_EQ: return z;
            COND_NE: return ~z;
            COND_CS: return c;
            COND_CC: return ~c;
            COND_MI: return n;
            COND_PL: return ~n;
            COND_VS: return v;
            COND_VC: return ~v;
            COND_HI: return c & ~z;
            COND_LS: return ~(c & ~z);
            COND_GE: return n == v;
            COND_LT: return n != v;
            COND_GT: return ~z & (n == v);
            COND_LE: return ~(~z & (n == v));
            COND_AL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cond_logic.sv
// Conditional-execution unit: stored NZCV flags, condition check,
// delayed condition flop and gating of the architectural write enables.
module cond_logic
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond_i,
    input  logic [3:0] alu_flags_i,
    input  logic [1:0] flag_w_i,
    input  logic       pcs_i,
    input  logic       next_pc_i,
    input  logic       reg_w_i,
    input  logic       mem_w_i,
    output logic       pc_write_o,
    output logic       reg_write_o,
    output logic       mem_write_o
);

    logic [3:0] flags_q, flags_d;
    logic       cond_ex;
    logic       cond_ex_q;

    assign cond_ex = cond_holds(cond_i, flags_q);

    always_comb begin
        flags_d = flags_q;
        if (flag_w_i[1] && cond_ex) flags_d[3:2] = alu_flags_i[3:2];
        if (flag_w_i[0] && cond_ex) flags_d[1:0] = alu_flags_i[1:0];
    end

    // NOTE: reset is tested inside the clocked block, so it only acts on a clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q   <= 4'b0000;
            cond_ex_q <= 1'b0;
        end else begin
            flags_q   <= flags_d;
            cond_ex_q <= cond_ex;
        end
    end

    // Write-back states use the condition sampled in the previous cycle.
    assign pc_write_o  = ~reset & (next_pc_i | (pcs_i & cond_ex_q));
    assign reg_write_o = ~reset & reg_w_i & cond_ex_q;
    assign mem_write_o = ~reset & mem_w_i & cond_ex_q;

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: Moore main FSM and ALU decoder driving the
// datapath selects, with conditional execution handled by cond_logic.
module multicycle_controller
    import ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [31:12] Instr,
    input  logic [3:0]   ALUFlags,
    output logic         PCWrite,
    output logic         MemWrite,
    output logic         RegWrite,
    output logic         IRWrite,
    output logic         AdrSrc,
    output logic [1:0]   RegSrc,
    output logic [1:0]   ALUSrcA,
    output logic [1:0]   ALUSrcB,
    output logic [1:0]   ResultSrc,
    output logic [1:0]   ImmSrc,
    output logic [2:0]   ALUControl
);

    state_t     state_q, state_d;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       ir_w, next_pc, reg_w, mem_w, branch, alu_op;
    logic [1:0] flag_w;
    logic       pcs;
    logic       unused_rn;

    assign op        = Instr[27:26];
    assign funct     = Instr[25:20];
    assign rd        = Instr[15:12];
    assign unused_rn = ^Instr[19:16];

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_UNKNOWN;
                endcase
            end
            S_MEMADR:   state_d = funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        ir_w      = 1'b0;
        next_pc   = 1'b0;
        reg_w     = 1'b0;
        mem_w     = 1'b0;
        branch    = 1'b0;
        alu_op    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = SRCA_REG;
        ALUSrcB   = SRCB_WDATA;
        ResultSrc = RES_ALUOUT;
        case (state_q)
            S_FETCH: begin
                ir_w      = 1'b1;
                next_pc   = 1'b1;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_DECODE: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_MEMADR:   ALUSrcB = SRCB_IMM;
            S_MEMRD:    AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_w     = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
            end
            S_EXECUTER: alu_op = 1'b1;
            S_EXECUTEI: begin
                alu_op  = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_ALUWB:    reg_w = 1'b1;
            S_BRANCH: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    // Unsupported commands fall back to ADD and never touch the flags.
    always_comb begin
        ALUControl = ALU_ADD;
        flag_w     = 2'b00;
        if (alu_op) begin
            case (funct[4:1])
                4'b0100: begin ALUControl = ALU_ADD; flag_w = {2{funct[0]}}; end
                4'b0010: begin ALUControl = ALU_SUB; flag_w = {2{funct[0]}}; end
                4'b0000: begin ALUControl = ALU_AND; flag_w = {funct[0], 1'b0}; end
                4'b1100: begin ALUControl = ALU_ORR; flag_w = {funct[0], 1'b0}; end
                4'b0001: begin ALUControl = ALU_EOR; flag_w = {funct[0], 1'b0}; end
                default: ;
            endcase
        end
    end

    assign RegSrc  = {op == OP_MEM, op == OP_BR};
    assign ImmSrc  = op;
    assign pcs     = (reg_w & (rd == 4'hF)) | branch;
    assign IRWrite = ir_w & ~reset;

    cond_logic u_cond_logic (
        .clk         (clk),
        .reset       (reset),
        .cond_i      (Instr[31:28]),
        .alu_flags_i (ALUFlags),
        .flag_w_i    (flag_w),
        .pcs_i       (pcs),
        .next_pc_i   (next_pc),
        .reg_w_i     (reg_w),
        .mem_w_i     (mem_w),
        .pc_write_o  (PCWrite),
        .reg_write_o (RegWrite),
        .mem_write_o (MemWrite)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks instruction sequences and
// compares the per-cycle control word and write enables with hand-derived values.
module tb_multicycle_controller;

    logic         clk;
    logic         reset;
    logic [31:12] Instr;
    logic [3:0]   ALUFlags;
    logic         PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0]   RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0]   ALUControl;

    int n_checks = 0;
    int n_errors = 0;

    // Control word {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl}
    localparam logic [11:0] C_FETCH  = 12'b1_0_10_10_10_000;
    localparam logic [11:0] C_DECODE = 12'b0_0_10_10_10_000;
    localparam logic [11:0] C_MEMADR = 12'b0_0_00_01_00_000;
    localparam logic [11:0] C_MEMRD  = 12'b0_1_00_00_00_000;
    localparam logic [11:0] C_MEMWB  = 12'b0_0_00_00_01_000;
    localparam logic [11:0] C_MEMWR  = 12'b0_1_00_00_00_000;
    localparam logic [11:0] C_EXECI  = 12'b0_0_00_01_00_000;
    localparam logic [11:0] C_ALUWB  = 12'b0_0_00_00_00_000;
    localparam logic [11:0] C_BRANCH = 12'b0_0_10_01_10_000;
    localparam logic [11:0] C_UNK    = 12'b0_0_00_00_00_000;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .RegSrc     (RegSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [11:0] actual, input logic [11:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Check the current cycle, then advance to 1 time unit after the next rising edge.
    task automatic expect_cyc(input string tag, input logic [11:0] ctl, input logic [2:0] we);
        #1;
        check({tag, ".ctl"}, {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl}, ctl);
        check({tag, ".we"}, {9'b0, PCWrite, MemWrite, RegWrite}, {9'b0, we});
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from FETCH; wb_we is {PCWrite,MemWrite,RegWrite} in its last state.
    task automatic run_instr(input string name, input logic [19:0] ins, input logic [3:0] flags,
                             input logic [2:0] alu, input logic [2:0] wb_we);
        logic [1:0] op;
        op       = ins[15:14];
        Instr    = ins;
        ALUFlags = flags;
        expect_cyc({name, ".fetch"}, C_FETCH, 3'b100);
        #1;
        check({name, ".immsrc"}, {10'b0, ImmSrc}, {10'b0, op});
        check({name, ".regsrc"}, {10'b0, RegSrc}, {10'b0, op == 2'b01, op == 2'b10});
        expect_cyc({name, ".decode"}, C_DECODE, 3'b000);
        case (op)
            2'b00: begin
                if (ins[13]) expect_cyc({name, ".execi"}, C_EXECI | {9'b0, alu}, 3'b000);
                else         expect_cyc({name, ".execr"}, {9'b0, alu}, 3'b000);
                expect_cyc({name, ".aluwb"}, C_ALUWB, wb_we);
            end
            2'b01: begin
                expect_cyc({name, ".memadr"}, C_MEMADR, 3'b000);
                if (ins[8]) begin
                    expect_cyc({name, ".memrd"}, C_MEMRD, 3'b000);
                    expect_cyc({name, ".memwb"}, C_MEMWB, wb_we);
                end else begin
                    expect_cyc({name, ".memwr"}, C_MEMWR, wb_we);
                end
            end
            2'b10:   expect_cyc({name, ".branch"}, C_BRANCH, wb_we);
            default: expect_cyc({name, ".unknown"}, C_UNK, wb_we);
        endcase
    endtask

    initial begin
        reset    = 1'b1;
        Instr    = '0;
        ALUFlags = 4'b0000;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("reset%0d.we", i), {9'b0, PCWrite, MemWrite, RegWrite}, 12'h000);
            check($sformatf("reset%0d.irw", i), {11'b0, IRWrite}, 12'h000);
        end
        reset = 1'b0;

        // ADDS sets Z; BEQ taken
        run_instr("adds_z",   20'hE0921, 4'b0100, 3'b000, 3'b001);
        run_instr("beq_t",    20'h0A000, 4'b0000, 3'b000, 3'b100);
        // ADDS clears flags; BEQ not taken
        run_instr("adds_clr", 20'hE0921, 4'b0000, 3'b000, 3'b001);
        run_instr("beq_nt",   20'h0A000, 4'b0000, 3'b000, 3'b000);
        run_instr("ldr",      20'hE5910, 4'b0000, 3'b000, 3'b001);
        run_instr("str",      20'hE5810, 4'b0000, 3'b000, 3'b010);
        // SUBS sets Z, ADDNE suppressed, flags untouched so BEQ still taken
        run_instr("subs_z",   20'hE0500, 4'b0100, 3'b001, 3'b001);
        run_instr("addne",    20'h12844, 4'b0000, 3'b000, 3'b000);
        run_instr("beq_t2",   20'h0A000, 4'b0000, 3'b000, 3'b100);
        run_instr("and",      20'hE0021, 4'b0000, 3'b010, 3'b001);
        run_instr("eor",      20'hE0221, 4'b0000, 3'b100, 3'b001);
        run_instr("orr",      20'hE1821, 4'b0000, 3'b011, 3'b001);
        // Unsupported command: ADD code, flags must not change
        run_instr("cmp_inv",  20'hE1501, 4'b0000, 3'b000, 3'b001);
        run_instr("beq_t3",   20'h0A000, 4'b0000, 3'b000, 3'b100);
        run_instr("add_pc",   20'hE082F, 4'b0000, 3'b000, 3'b101);
        run_instr("add_nv",   20'hF0821, 4'b0000, 3'b000, 3'b000);
        // NZCV=0011: GE false, CS true; ANDS then loads only N,Z -> N=1,V=1 so GE true
        run_instr("adds_cv",  20'hE0921, 4'b0011, 3'b000, 3'b001);
        run_instr("addge_f",  20'hA0821, 4'b0000, 3'b000, 3'b000);
        run_instr("addcs_t",  20'h20821, 4'b0000, 3'b000, 3'b001);
        run_instr("ands_n",   20'hE0121, 4'b1000, 3'b010, 3'b001);
        run_instr("addge_t",  20'hA0821, 4'b0000, 3'b000, 3'b001);
        run_instr("addls_f",  20'h90821, 4'b0000, 3'b000, 3'b000);
        run_instr("unknown",  20'hEC000, 4'b0000, 3'b000, 3'b000);

        // Reset asserted in MEMWR aborts the store
        Instr = 20'hE5810;
        expect_cyc("rst_str.fetch",  C_FETCH,  3'b100);
        expect_cyc("rst_str.decode", C_DECODE, 3'b000);
        expect_cyc("rst_str.memadr", C_MEMADR, 3'b000);
        reset = 1'b1;
        #1;
        check("rst_str.memwr.we", {9'b0, PCWrite, MemWrite, RegWrite}, 12'h000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        expect_cyc("rst_str.after", C_FETCH, 3'b100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
